// File: rtl/mips_hazard_scoreboard.sv
// Hazard and forwarding scoreboard for the pipelined MIPS core.
// A DEPTH-entry shift table tracks every in-flight writer after ID
// (entry 0 = ID/EX ... entry DEPTH-1 = last WB). From the registered table it
// derives the ID stall request and the EX operand-forward selects, and it
// counts stall cycles.
module mips_hazard_scoreboard #(
  parameter int REG_AW     = 5,
  parameter int DEPTH      = 3,
  parameter int ALU_READY  = 1,
  parameter int LOAD_READY = 2,
  parameter int CNT_W      = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     id_valid,
  input  logic [REG_AW-1:0]        id_rs,
  input  logic [REG_AW-1:0]        id_rt,
  input  logic                     id_use_rs,
  input  logic                     id_use_rt,
  input  logic [REG_AW-1:0]        id_dest,
  input  logic                     id_regwrite,
  input  logic                     id_is_load,
  input  logic                     id_flush,
  input  logic                     pipe_hold,
  output logic                     stall_id,
  output logic [$clog2(DEPTH)-1:0] fwd_a,
  output logic [$clog2(DEPTH)-1:0] fwd_b,
  output logic [CNT_W-1:0]         stall_cnt
);

  localparam int FW = $clog2(DEPTH);

  // One tracked writer. The source fields are only consulted in entry 0
  // (the instruction currently in EX); they ride along harmlessly elsewhere.
  typedef struct packed {
    logic              valid;
    logic              wr;
    logic              is_load;
    logic [REG_AW-1:0] dest;
    logic              use_a;
    logic              use_b;
    logic [REG_AW-1:0] src_a;
    logic [REG_AW-1:0] src_b;
  } entry_t;

  entry_t           tbl_q [DEPTH];
  entry_t           tbl_d [DEPTH];
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             hazard;
  logic             stall;

  // First entry index at which this writer's result can be forwarded.
  function automatic int ready_of(input entry_t e);
    return e.is_load ? LOAD_READY : ALU_READY;
  endfunction

  // Entry e produces register r. Register 0 is hard-wired and never matches.
  function automatic logic match(input entry_t e, input logic [REG_AW-1:0] r);
    return e.valid && e.wr && (e.dest == r) && (r != '0);
  endfunction

  // Stall when a producer the ID instruction needs will not yet be
  // forwardable by the time the consumer reaches EX.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    hazard = 1'b0;
    for (int k = 0; k < DEPTH - 1; k++) begin
      if ((k + 1 < ready_of(tbl_q[k])) &&
          ((id_use_rs && match(tbl_q[k], id_rs)) ||
           (id_use_rt && match(tbl_q[k], id_rt)))) begin
        hazard = 1'b1;
      end
    end
    // A flushed or frozen ID instruction cannot request a stall.
    stall = id_valid && !id_flush && !pipe_hold && hazard;
  end

  // Forward selects for the EX instruction: the youngest ready producer wins,
  // so scan oldest to youngest and let later hits overwrite earlier ones.
  always_comb begin
    fwd_a = '0;
    fwd_b = '0;
    for (int j = DEPTH - 1; j >= 1; j--) begin
      if (tbl_q[0].use_a && match(tbl_q[j], tbl_q[0].src_a) && (j >= ready_of(tbl_q[j])))
        fwd_a = FW'(j);
      if (tbl_q[0].use_b && match(tbl_q[j], tbl_q[0].src_b) && (j >= ready_of(tbl_q[j])))
        fwd_b = FW'(j);
    end
  end

  // Next-state table and stall counter: shift one stage per cycle unless the
  // whole pipe is held; entry 0 takes the ID instruction or a bubble.
  always_comb begin
    tbl_d = tbl_q;
    cnt_d = cnt_q;
    if (!pipe_hold) begin
      for (int k = DEPTH - 1; k >= 1; k--) begin
        tbl_d[k] = tbl_q[k - 1];
      end
      tbl_d[0] = '0;
      if (id_valid && !id_flush && !stall) begin
        tbl_d[0] = '{valid:   1'b1,
                     wr:      id_regwrite,
                     is_load: id_is_load,
                     dest:    id_dest,
                     use_a:   id_use_rs,
                     use_b:   id_use_rt,
                     src_a:   id_rs,
                     src_b:   id_rt};
      end
      if (stall) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the table is a handful of flops, not a RAM, and stale valid
      // bits would cause phantom stalls, so every entry is cleared on reset.
      for (int k = 0; k < DEPTH; k++) begin
        tbl_q[k] <= '0;
      end
      cnt_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge value, independent of statement order.
      tbl_q <= tbl_d;
      cnt_q <= cnt_d;
    end
  end

  assign stall_id  = stall;
  assign stall_cnt = cnt_q;

endmodule
